// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw pins in, debounced levels and event pulses out.
interface button_debouncer_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_state;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] released;
  logic [NUM_BTN-1:0] repeat_evt;
  logic               any_pressed;

  modport master (
    output btn_in,
    input  btn_state, pressed, released, repeat_evt, any_pressed
  );

  modport slave (
    input  btn_in,
    output btn_state, pressed, released, repeat_evt, any_pressed
  );
endinterface

// File: rtl/button_debouncer.sv
// Per-channel two-flop synchroniser, stable-count debouncer and auto-repeat FSM
// producing a clean level plus registered press/release/repeat pulses.
module button_debouncer #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 320000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 16000000,
  parameter int unsigned REPEAT_RATE     = 3200000,
  parameter int unsigned REP_W           = 24
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] state;
  logic [NUM_BTN-1:0] pressed_q;
  logic [NUM_BTN-1:0] released_q;
  logic [NUM_BTN-1:0] repeat_q;
  logic [NUM_BTN-1:0] accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [REP_W-1:0] rc;
    rep_state_t       rstate;

    // A level change is accepted on the edge where the mismatch has persisted long enough.
    assign accept[g] = (sync2[g] != state[g]) && (cnt == DB_LAST);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt           <= '0;
        state[g]      <= 1'b0;
        pressed_q[g]  <= 1'b0;
        released_q[g] <= 1'b0;
      end else begin
        pressed_q[g]  <= accept[g] & ~state[g];
        released_q[g] <= accept[g] & state[g];
        if (accept[g]) begin
          state[g] <= ~state[g];
          cnt      <= '0;
        end else if (sync2[g] == state[g]) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset || !REPEAT_EN) begin
        rstate      <= IDLE;
        rc          <= '0;
        repeat_q[g] <= 1'b0;
      end else begin
        repeat_q[g] <= 1'b0;
        case (rstate)
          IDLE: begin
            rc <= '0;
            if (accept[g] && !state[g]) rstate <= HOLD;
          end
          HOLD, REPEAT: begin
            // Release wins over a repeat that would fire on the same edge.
            if (accept[g] && state[g]) begin
              rstate <= IDLE;
              rc     <= '0;
            end else if (rc == ((rstate == HOLD) ? DELAY_LAST : RATE_LAST)) begin
              repeat_q[g] <= 1'b1;
              rc          <= '0;
              rstate      <= REPEAT;
            end else begin
              rc <= rc + 1'b1;
            end
          end
          default: begin
            rstate <= IDLE;
            rc     <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_state   = state;
  assign bus.pressed     = pressed_q;
  assign bus.released    = released_q;
  assign bus.repeat_evt  = repeat_q;
  assign bus.any_pressed = |pressed_q;

endmodule
